// File: rtl/dmem_bus_arbiter_if.sv
`default_nettype none
// ============================================================================
// dmem_bus_arbiter_if : two requester ports plus the shared memory-side bus
// Rev 1.0
// ============================================================================
interface dmem_bus_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) ();
   logic              m0_req;
   logic              m0_we;
   logic [ADDR_W-1:0] m0_addr;
   logic [DATA_W-1:0] m0_wdata;
   logic              m0_ack;
   logic [DATA_W-1:0] m0_rdata;

   logic              m1_req;
   logic              m1_we;
   logic [ADDR_W-1:0] m1_addr;
   logic [DATA_W-1:0] m1_wdata;
   logic              m1_ack;
   logic [DATA_W-1:0] m1_rdata;

   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic              mem_we;
   logic              mem_io_sel;
   logic [DATA_W-1:0] mem_rdata;

   logic              busy;
   logic              grant_id;

   modport slave (
      input  m0_req, m0_we, m0_addr, m0_wdata,
      output m0_ack, m0_rdata,
      input  m1_req, m1_we, m1_addr, m1_wdata,
      output m1_ack, m1_rdata,
      output mem_addr, mem_wdata, mem_we, mem_io_sel,
      input  mem_rdata,
      output busy, grant_id
   );

   modport master (
      output m0_req, m0_we, m0_addr, m0_wdata,
      input  m0_ack, m0_rdata,
      output m1_req, m1_we, m1_addr, m1_wdata,
      input  m1_ack, m1_rdata,
      input  mem_addr, mem_wdata, mem_we, mem_io_sel,
      output mem_rdata,
      input  busy, grant_id
   );
endinterface
`default_nettype wire

// File: rtl/dmem_bus_arbiter.sv
`default_nettype none
// ============================================================================
// dmem_bus_arbiter : round-robin two-master sequencer for the data-memory/IO bus
// Rev 1.0
// ============================================================================
module dmem_bus_arbiter #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int IO_BIT = 7,
   parameter int RD_LAT = 1
) (
   input  logic              clock,
   input  logic              reset,
   dmem_bus_arbiter_if.slave bus
);
   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   localparam logic [1:0] C_LAT_LOAD = 2'(RD_LAT - 1);

   state_t            r_state;
   state_t            w_state_nxt;
   logic              r_last_grant;
   logic              r_grant_id;
   logic              r_we;
   logic              r_mem_we;
   logic              r_mem_io_sel;
   logic              r_m0_ack;
   logic              r_m1_ack;
   logic [1:0]        r_lat_cnt;
   logic [ADDR_W-1:0] r_mem_addr;
   logic [DATA_W-1:0] r_mem_wdata;
   logic [DATA_W-1:0] r_m0_rdata;
   logic [DATA_W-1:0] r_m1_rdata;

   logic              w_any_req;
   logic              w_winner;
   logic              w_win_we;
   logic [ADDR_W-1:0] w_win_addr;
   logic [DATA_W-1:0] w_win_wdata;

   // On a tie the master that was not served last wins.
   always_comb begin
      w_any_req   = bus.m0_req | bus.m1_req;
      w_winner    = bus.m1_req & (~bus.m0_req | ~r_last_grant);
      w_win_we    = w_winner ? bus.m1_we    : bus.m0_we;
      w_win_addr  = w_winner ? bus.m1_addr  : bus.m0_addr;
      w_win_wdata = w_winner ? bus.m1_wdata : bus.m0_wdata;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (w_any_req) w_state_nxt = S_ISSUE;
         S_ISSUE: w_state_nxt = r_we ? S_DONE : S_WAIT;
         S_WAIT:  if (r_lat_cnt == 2'd0) w_state_nxt = S_DONE;
         S_DONE:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_last_grant <= 1'b1;
         r_grant_id   <= 1'b0;
         r_we         <= 1'b0;
         r_mem_we     <= 1'b0;
         r_mem_io_sel <= 1'b0;
         r_m0_ack     <= 1'b0;
         r_m1_ack     <= 1'b0;
         r_lat_cnt    <= 2'd0;
         r_mem_addr   <= '0;
         r_mem_wdata  <= '0;
         r_m0_rdata   <= '0;
         r_m1_rdata   <= '0;
      end else begin
         r_mem_we <= 1'b0;
         r_m0_ack <= 1'b0;
         r_m1_ack <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_any_req) begin
                  r_grant_id   <= w_winner;
                  r_last_grant <= w_winner;
                  r_we         <= w_win_we;
                  r_mem_we     <= w_win_we;
                  r_mem_addr   <= w_win_addr;
                  r_mem_wdata  <= w_win_wdata;
                  r_mem_io_sel <= w_win_addr[IO_BIT];
               end
            end
            S_ISSUE: begin
               if (r_we) begin
                  r_m0_ack <= ~r_grant_id;
                  r_m1_ack <= r_grant_id;
               end else begin
                  r_lat_cnt <= C_LAT_LOAD;
               end
            end
            S_WAIT: begin
               // Read data lands in the granted master's register only.
               if (r_lat_cnt == 2'd0) begin
                  r_m0_ack <= ~r_grant_id;
                  r_m1_ack <= r_grant_id;
                  if (r_grant_id) r_m1_rdata <= bus.mem_rdata;
                  else            r_m0_rdata <= bus.mem_rdata;
               end else begin
                  r_lat_cnt <= r_lat_cnt - 2'd1;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.m0_ack     = r_m0_ack;
   assign bus.m1_ack     = r_m1_ack;
   assign bus.m0_rdata   = r_m0_rdata;
   assign bus.m1_rdata   = r_m1_rdata;
   assign bus.mem_addr   = r_mem_addr;
   assign bus.mem_wdata  = r_mem_wdata;
   assign bus.mem_we     = r_mem_we;
   assign bus.mem_io_sel = r_mem_io_sel;
   assign bus.busy       = (r_state != S_IDLE);
   assign bus.grant_id   = r_grant_id;
endmodule
`default_nettype wire

// File: tb/tb_dmem_bus_arbiter.sv
`default_nettype none
// ============================================================================
// tb_dmem_bus_arbiter : scoreboard bench for the two-master memory arbiter
// Rev 1.0
// ============================================================================
module tb_dmem_bus_arbiter;
   localparam int IO_BIT = 7;

   logic clock = 1'b0;
   logic reset = 1'b1;
   always #5 clock = ~clock;

   dmem_bus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus  ();
   dmem_bus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus3 ();

   dmem_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .IO_BIT(IO_BIT), .RD_LAT(1)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   dmem_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .IO_BIT(IO_BIT), .RD_LAT(3)) dut3 (
      .clock (clock),
      .reset (reset),
      .bus   (bus3)
   );

   // Memory model: fixed contents, synchronous read with 1 or 3 cycles of latency.
   function automatic logic [31:0] mem_f(input logic [31:0] a);
      return (a == 32'h8) ? 32'h1234_5678 : (a ^ 32'hA5A5_0000);
   endfunction

   logic [31:0] r_p1;
   logic [31:0] r_p3 [3];
   always @(posedge clock) begin
      r_p1    <= mem_f(bus.mem_addr);
      r_p3[0] <= mem_f(bus3.mem_addr);
      r_p3[1] <= r_p3[0];
      r_p3[2] <= r_p3[1];
   end
   assign bus.mem_rdata  = r_p1;
   assign bus3.mem_rdata = r_p3[2];

   typedef struct { bit id; bit rd; logic [31:0] rdata; } exp_t;
   typedef struct { logic [31:0] addr; logic [31:0] wdata; bit io; } wexp_t;
   exp_t  q_ack [$];
   wexp_t q_wr  [$];

   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: pops the scoreboard on every ack and every write strobe.
   bit    prev_we = 0, prev_busy = 0, armed = 0, gap_chk = 0;
   int    idle_run = 0;
   exp_t  mon_e;
   wexp_t mon_w;
   initial begin : monitor
      forever begin
         @(negedge clock);
         if (bus.m0_ack || bus.m1_ack) begin
            check("ack_overlap", 64'(bus.m0_ack & bus.m1_ack), 64'd0);
            if (q_ack.size() == 0) begin
               n_vec++; n_err++;
               $display("FAIL unexpected_ack: got m0_ack=%0b m1_ack=%0b, expected none", bus.m0_ack, bus.m1_ack);
            end else begin
               mon_e = q_ack.pop_front();
               check("ack_id", 64'(bus.m1_ack), 64'(mon_e.id));
               check("grant_id", 64'(bus.grant_id), 64'(mon_e.id));
               if (mon_e.rd)
                  check("rdata", 64'(mon_e.id ? bus.m1_rdata : bus.m0_rdata), 64'(mon_e.rdata));
            end
         end
         if (bus.mem_we) begin
            check("we_one_cycle", 64'(prev_we), 64'd0);
            if (q_wr.size() == 0) begin
               n_vec++; n_err++;
               $display("FAIL unexpected_write: got mem_we=1 addr=0x%0h, expected none", bus.mem_addr);
            end else begin
               mon_w = q_wr.pop_front();
               check("wr_addr", 64'(bus.mem_addr), 64'(mon_w.addr));
               check("wr_data", 64'(bus.mem_wdata), 64'(mon_w.wdata));
               check("wr_io_sel", 64'(bus.mem_io_sel), 64'(mon_w.io));
            end
         end
         if (bus.busy && !prev_busy && armed) begin
            check("idle_gap", 64'(idle_run), 64'd1);
            armed = 0;
         end
         if (!bus.busy && prev_busy) begin
            idle_run = 1;
            armed    = gap_chk;
         end else if (!bus.busy) begin
            idle_run++;
         end
         prev_we   = bus.mem_we;
         prev_busy = bus.busy;
      end
   end

   initial begin : watchdog
      #100000;
      $display("FAIL watchdog: got no finish, expected end of test");
      $fatal(1);
   end

   task automatic drive(input bit id, input bit req, input bit we, input logic [31:0] addr, input logic [31:0] wdata);
      if (id) begin
         bus.m1_req = req; bus.m1_we = we; bus.m1_addr = addr; bus.m1_wdata = wdata;
      end else begin
         bus.m0_req = req; bus.m0_we = we; bus.m0_addr = addr; bus.m0_wdata = wdata;
      end
   endtask

   // Presents one request, waits for its ack and checks request-to-ack latency.
   task automatic txn(input bit id, input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [31:0] rdata_exp, input int exp_lat, input bit sb);
      bit got = 0;
      int lat = 0;
      if (sb) begin
         q_ack.push_back('{id, !we, rdata_exp});
         if (we) q_wr.push_back('{addr, wdata, addr[IO_BIT]});
      end
      drive(id, 1'b1, we, addr, wdata);
      for (int c = 1; c <= 40; c++) begin
         @(negedge clock);
         if (!got && (id ? bus.m1_ack : bus.m0_ack)) begin
            got = 1;
            lat = c;
         end
         @(posedge clock); #1;
         if (got) break;
      end
      drive(id, 1'b0, 1'b0, 32'h0, 32'h0);
      check("ack_seen", 64'(got), 64'd1);
      check("ack_latency", 64'(lat), 64'(exp_lat));
   endtask

   task automatic do_reset();
      reset = 1'b1;
      repeat (2) @(posedge clock);
      #1 reset = 1'b0;
   endtask

   bit got3;
   int lat3, n_ack;

   initial begin : stim
      drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
      bus3.m0_req = 0; bus3.m0_we = 0; bus3.m0_addr = 0; bus3.m0_wdata = 0;
      bus3.m1_req = 0; bus3.m1_we = 0; bus3.m1_addr = 0; bus3.m1_wdata = 0;
      repeat (3) @(posedge clock);
      #1 reset = 1'b0;

      @(negedge clock);
      check("rst_busy", 64'(bus.busy), 64'd0);
      check("rst_mem_we", 64'(bus.mem_we), 64'd0);
      check("rst_acks", 64'({bus.m0_ack, bus.m1_ack}), 64'd0);
      check("rst_grant_id", 64'(bus.grant_id), 64'd0);
      check("rst_mem_addr", 64'(bus.mem_addr), 64'd0);
      check("rst_m1_rdata", 64'(bus.m1_rdata), 64'd0);
      @(posedge clock); #1;

      txn(1'b0, 1'b1, 32'h14, 32'hDEAD_BEEF, 32'h0, 3, 1'b1);
      txn(1'b1, 1'b0, 32'h08, 32'h0, 32'h1234_5678, 4, 1'b1);

      // Both masters from reset: expected grant order 0,1,0,1.
      do_reset();
      q_ack.push_back('{1'b0, 1'b0, 32'h0});
      q_ack.push_back('{1'b1, 1'b0, 32'h0});
      q_ack.push_back('{1'b0, 1'b1, 32'hA5A5_0020});
      q_ack.push_back('{1'b1, 1'b1, 32'hA5A5_0024});
      q_wr.push_back('{32'h100, 32'h1111_1111, 1'b0});
      q_wr.push_back('{32'h200, 32'h2222_2222, 1'b0});
      gap_chk = 1;
      fork
         begin
            txn(1'b0, 1'b1, 32'h100, 32'h1111_1111, 32'h0, 3, 1'b0);
            txn(1'b0, 1'b0, 32'h20, 32'h0, 32'hA5A5_0020, 7, 1'b0);
         end
         begin
            txn(1'b1, 1'b1, 32'h200, 32'h2222_2222, 32'h0, 6, 1'b0);
            txn(1'b1, 1'b0, 32'h24, 32'h0, 32'hA5A5_0024, 8, 1'b0);
         end
      join
      gap_chk = 0;

      txn(1'b0, 1'b1, 32'h80, 32'hCAFE_0080, 32'h0, 3, 1'b1);
      txn(1'b0, 1'b1, 32'h7C, 32'hCAFE_007C, 32'h0, 3, 1'b1);
      @(negedge clock);
      check("rdata_kept_over_writes", 64'(bus.m0_rdata), 64'hA5A5_0020);
      @(posedge clock); #1;

      // Reset during WAIT aborts the read with no ack.
      drive(1'b0, 1'b1, 1'b0, 32'h30, 32'h0);
      @(posedge clock); #1;
      @(posedge clock); #1;
      reset = 1'b1;
      drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      @(posedge clock); #1;
      reset = 1'b0;
      @(negedge clock);
      check("abort_busy", 64'(bus.busy), 64'd0);
      check("abort_mem_we", 64'(bus.mem_we), 64'd0);
      check("abort_m0_ack", 64'(bus.m0_ack), 64'd0);
      repeat (3) @(posedge clock);
      #1;
      txn(1'b0, 1'b0, 32'h08, 32'h0, 32'h1234_5678, 4, 1'b1);

      // m1 drops req during ISSUE; the read still completes with one ack.
      q_ack.push_back('{1'b1, 1'b1, 32'hA5A5_0010});
      drive(1'b1, 1'b1, 1'b0, 32'h10, 32'h0);
      @(posedge clock); #1;
      drive(1'b1, 1'b0, 1'b0, 32'h10, 32'h0);
      n_ack = 0;
      for (int c = 2; c <= 10; c++) begin
         @(negedge clock);
         if (bus.m1_ack) n_ack++;
         @(posedge clock); #1;
      end
      check("drop_ack_count", 64'(n_ack), 64'd1);
      @(negedge clock);
      check("drop_busy_idle", 64'(bus.busy), 64'd0);
      @(posedge clock); #1;

      // RD_LAT=3 instance: m1 read of 0x08 acks in cycle 6.
      bus3.m1_req = 1; bus3.m1_we = 0; bus3.m1_addr = 32'h08;
      got3 = 0; lat3 = 0;
      for (int c = 1; c <= 40; c++) begin
         @(negedge clock);
         if (!got3 && bus3.m1_ack) begin
            got3 = 1;
            lat3 = c;
            check("rl3_rdata", 64'(bus3.m1_rdata), 64'h1234_5678);
            check("rl3_m0_ack", 64'(bus3.m0_ack), 64'd0);
         end
         @(posedge clock); #1;
         if (got3) break;
      end
      bus3.m1_req = 0;
      check("rl3_ack_seen", 64'(got3), 64'd1);
      check("rl3_latency", 64'(lat3), 64'd6);

      repeat (3) @(posedge clock);
      #1;
      check("sb_ack_drained", 64'(q_ack.size()), 64'd0);
      check("sb_wr_drained", 64'(q_wr.size()), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
`default_nettype wire
